mat_mult_host_port: RTL and testbench

- Hardware counterpart to the mat_mult bench: the initiator side of the mat_mult interface, driven by software.
- A host bus writes two 4x4 fixed-point operand matrices (A, B) element by element, then issues start.
- The block presents the operands to mat_mult, pulses its start, waits for done, captures the 16-element product C, and exposes C and status for reads, with an optional interrupt.
- Sits between the Avalon-style slave bus and mat_mult in the IK datapath.

---
 rtl/mat_mult_pkg.sv | 38 +++
 rtl/mat_mult_host_regs.sv | 84 ++++++++
 rtl/mat_mult_host_port.sv | 107 ++++++++++
 tb/tb_mat_mult_host_port.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// rtl/mat_mult_pkg.sv - shared constants, types and encodings for the mat_mult host port
package mat_mult_pkg;

    localparam int DW = 36;
    localparam int N  = 4;
    localparam int NE = N * N;
    localparam int CW = 16;

    typedef logic signed [DW-1:0] elem_t;
    typedef elem_t [NE-1:0]       mat_t;

    typedef enum logic [1:0] {
        REGION_A    = 2'b00,
        REGION_B    = 2'b01,
        REGION_C    = 2'b10,
        REGION_CTRL = 2'b11
    } region_e;

    localparam logic [6:0] ADDR_CTRL   = 7'h60;
    localparam logic [6:0] ADDR_CYCLES = 7'h61;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Upper bits of an element, sign-extended to a full 32-bit bus word.
    function automatic logic [31:0] hi_sext(elem_t e);
        return {{(64-DW){e[DW-1]}}, e[DW-1:32]};
    endfunction

endpackage

// File: rtl/mat_mult_host_regs.sv
// rtl/mat_mult_host_regs.sv - A/B/C operand storage, half-word access and registered read mux
module mat_mult_host_regs
    import mat_mult_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic [6:0]    addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          busy_i,
    input  logic [2:0]    status_i,
    input  logic [CW-1:0] cycles_i,
    input  logic          capture_i,
    input  mat_t          mm_c_i,
    output logic [31:0]   rdata_o,
    output mat_t          a_o,
    output mat_t          b_o
);

    mat_t        a_q, b_q, c_q;
    logic [31:0] rdata_d, rdata_q;
    elem_t       sel;
    region_e     region;
    logic        half;
    logic [3:0]  idx;

    assign region = region_e'(addr_i[6:5]);
    assign half   = addr_i[4];
    assign idx    = addr_i[3:0];

    // Host writes to A/B (frozen while an operation runs) and capture of the product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            if (wr_en_i && !busy_i) begin
                case (region)
                    REGION_A: begin
                        if (half) a_q[idx][DW-1:32] <= wdata_i[DW-33:0];
                        else      a_q[idx][31:0]    <= wdata_i;
                    end
                    REGION_B: begin
                        if (half) b_q[idx][DW-1:32] <= wdata_i[DW-33:0];
                        else      b_q[idx][31:0]    <= wdata_i;
                    end
                    default: ;
                endcase
            end
            if (capture_i) c_q <= mm_c_i;
        end
    end

    // Read mux: element halves for A/B/C, status and cycle count in the ctrl region.
    always_comb begin
        rdata_d = '0;
        sel     = '0;
        case (region)
            REGION_A: sel = a_q[idx];
            REGION_B: sel = b_q[idx];
            REGION_C: sel = c_q[idx];
            default:  sel = '0;
        endcase
        if (region == REGION_CTRL) begin
            if (addr_i == ADDR_CTRL)        rdata_d = {29'b0, status_i};
            else if (addr_i == ADDR_CYCLES) rdata_d = {{(32-CW){1'b0}}, cycles_i};
        end else begin
            rdata_d = half ? hi_sext(sel) : sel[31:0];
        end
    end

    // Read data is registered and held until the next read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     rdata_q <= '0;
        else if (rd_en_i) rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

endmodule

// File: rtl/mat_mult_host_port.sv
// rtl/mat_mult_host_port.sv - host-bus initiator for mat_mult: control FSM, cycle counter, irq
module mat_mult_host_port
    import mat_mult_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [6:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [N*N*DW-1:0] mm_a,
    output logic [N*N*DW-1:0] mm_b,
    output logic              mm_start,
    input  logic [N*N*DW-1:0] mm_c,
    input  logic              mm_done
);

    state_e        state_q;
    logic          busy_q, done_q, err_q, irq_en_q, mm_start_q;
    logic [CW-1:0] cnt_q;
    logic          wr_en, rd_en, ctrl_wr, start_req, clear_req, capture;
    mat_t          a_w, b_w;

    assign wr_en     = chipselect & write;
    assign rd_en     = chipselect & read;
    assign ctrl_wr   = wr_en & (address == ADDR_CTRL);
    assign start_req = ctrl_wr & writedata[CTRL_START];
    assign clear_req = ctrl_wr & writedata[CTRL_CLEAR];
    // A late mm_done is only meaningful while an operation is outstanding.
    assign capture   = (state_q == ST_WAIT) & mm_done;

    // Operation sequencer: issue start, wait for done or timeout, keep sticky status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            mm_start_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mm_start_q <= 1'b0;
            if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
            if (clear_req) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_req) begin
                        state_q    <= ST_ISSUE;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        mm_start_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mm_done) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mat_mult_host_regs u_regs (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_en),
        .rd_en_i   (rd_en),
        .addr_i    (address),
        .wdata_i   (writedata),
        .busy_i    (busy_q),
        .status_i  ({err_q, done_q, busy_q}),
        .cycles_i  (cnt_q),
        .capture_i (capture),
        .mm_c_i    (mm_c),
        .rdata_o   (readdata),
        .a_o       (a_w),
        .b_o       (b_w)
    );

    assign mm_a     = a_w;
    assign mm_b     = b_w;
    assign mm_start = mm_start_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_mat_mult_host_port.sv
// tb/tb_mat_mult_host_port.sv - self-checking bench for mat_mult_host_port
module tb_mat_mult_host_port;
    import mat_mult_pkg::*;

    localparam int TMO  = 1024;
    localparam int FRAC = 16;
    localparam int W    = N * N * DW;

    logic          clk = 1'b0;
    logic          reset_n, chipselect, write, read;
    logic [6:0]    address;
    logic [31:0]   writedata, readdata;
    logic          irq, mm_start, mm_done;
    logic [W-1:0]  mm_a, mm_b, mm_c;
    logic          stub_done, man_done;
    logic [W-1:0]  stub_c, man_c;

    longint a_m [16];
    longint b_m [16];
    longint c_m [16];
    int     stub_delay = 0;
    int     start_pulses;
    int     n_pass = 0;
    int     n_total = 0;

    typedef struct {
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [$];

    assign mm_done = stub_done | man_done;
    assign mm_c    = man_done ? man_c : stub_c;

    always #5 clk = ~clk;

    mat_mult_host_port #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_start   (mm_start),
        .mm_c       (mm_c),
        .mm_done    (mm_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [6:0] ea(input logic [1:0] r, input logic h, input int i);
        logic [3:0] ix;
        ix = i[3:0];
        return {r, h, ix};
    endfunction

    function automatic logic [W-1:0] pack(input longint m [16]);
        logic [W-1:0] p;
        logic [63:0]  x;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            x = m[i];
            p[i*DW +: DW] = x[DW-1:0];
        end
        return p;
    endfunction

    function automatic logic [31:0] lo_of(input longint v);
        logic [63:0] x;
        x = v;
        return x[31:0];
    endfunction

    function automatic logic [31:0] hi_of(input longint v);
        longint s;
        s = v >>> 32;
        return lo_of(s);
    endfunction

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic write_elem(input logic [1:0] r, input int i, input longint v);
        logic [63:0] x;
        logic [31:0] junk;
        x = v;
        junk = $urandom();
        junk[3:0] = x[35:32];
        bus_write(ea(r, 1'b0, i), x[31:0]);
        bus_write(ea(r, 1'b1, i), junk);
    endtask

    task automatic load_mats();
        for (int i = 0; i < 16; i++) begin
            write_elem(2'b00, i, a_m[i]);
            write_elem(2'b01, i, b_m[i]);
        end
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < 16; i++) begin
            a_m[i] = longint'($urandom_range(0, 2097151)) - 64'sd1048576;
            b_m[i] = longint'($urandom_range(0, 2097151)) - 64'sd1048576;
        end
    endtask

    // Fixed-point matrix product: row-major, sum of products, then drop FRAC bits.
    task automatic compute_ref();
        longint s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += a_m[i*N+k] * b_m[k*N+j];
                c_m[i*N+j] = s >>> FRAC;
            end
    endtask

    task automatic check_c(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            bus_read(ea(2'b10, 1'b0, i), d);
            check($sformatf("%s C[%0d] lo", tag, i), d, lo_of(c_m[i]));
            bus_read(ea(2'b10, 1'b1, i), d);
            check($sformatf("%s C[%0d] hi", tag, i), d, hi_of(c_m[i]));
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        int k;
        for (k = 0; k < 1500; k++) begin
            bus_read(ADDR_CTRL, st);
            if (st[2:1] != 2'b00) break;
        end
        check($sformatf("%s completes within bound", tag), k < 1500, 1);
    endtask

    task automatic run_op(input string tag, input int delay, input logic [31:0] ctrl,
                          input logic [2:0] exp_st, input int exp_cyc);
        logic [31:0] d;
        int p0;
        stub_delay = delay;
        p0 = start_pulses;
        bus_write(ADDR_CTRL, ctrl);
        wait_done(tag);
        bus_read(ADDR_CTRL, d);
        check($sformatf("%s status", tag), d, {29'b0, exp_st});
        bus_read(ADDR_CYCLES, d);
        check($sformatf("%s cycle count", tag), d, exp_cyc);
        check($sformatf("%s start pulses", tag), start_pulses - p0, 1);
    endtask

    // Count every mm_start cycle independently of the responder.
    initial begin
        start_pulses = 0;
        forever begin
            @(negedge clk);
            if (mm_start === 1'b1) start_pulses++;
        end
    end

    // mat_mult stand-in: checks operands at start, answers stub_delay cycles later.
    initial begin
        int bad;
        stub_done = 1'b0;
        stub_c    = '0;
        forever begin
            @(negedge clk);
            if (mm_start === 1'b1) begin
                bad = 0;
                if (mm_a !== pack(a_m)) bad++;
                if (mm_b !== pack(b_m)) bad++;
                check("operands at mm_start", bad, 0);
                if (stub_delay > 0) begin
                    repeat (stub_delay) @(negedge clk);
                    stub_c    = pack(c_m);
                    stub_done = 1'b1;
                    @(negedge clk);
                    stub_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [63:0] t;
        int p0;

        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; man_done = 1'b0; man_c = '0;
        for (int i = 0; i < 16; i++) begin a_m[i] = 0; b_m[i] = 0; c_m[i] = 0; end

        repeat (3) @(posedge clk); #1;
        check("reset readdata", readdata, 0);
        check("reset irq", irq, 0);
        check("reset mm_start", mm_start, 0);
        check("reset mm_a zero", mm_a == '0, 1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        tbl.push_back('{0, 7'h60, 32'h0, 32'h0});
        tbl.push_back('{0, 7'h61, 32'h0, 32'h0});
        tbl.push_back('{0, 7'h05, 32'h0, 32'h0});
        tbl.push_back('{1, 7'h15, 32'h0000000F, 32'h0});
        tbl.push_back('{1, 7'h05, 32'h00000001, 32'h0});
        tbl.push_back('{0, 7'h15, 32'h0, 32'hFFFFFFFF});
        tbl.push_back('{0, 7'h05, 32'h0, 32'h00000001});
        tbl.push_back('{1, 7'h2A, 32'h12345678, 32'h0});
        tbl.push_back('{1, 7'h3A, 32'hABCDE007, 32'h0});
        tbl.push_back('{0, 7'h3A, 32'h0, 32'h00000007});
        tbl.push_back('{0, 7'h2A, 32'h0, 32'h12345678});
        tbl.push_back('{1, 7'h41, 32'h0000DEAD, 32'h0});
        tbl.push_back('{0, 7'h41, 32'h0, 32'h0});
        tbl.push_back('{0, 7'h51, 32'h0, 32'h0});
        tbl.push_back('{0, 7'h62, 32'h0, 32'h0});
        tbl.push_back('{0, 7'h7F, 32'h0, 32'h0});
        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else begin
                bus_read(tbl[i].addr, d);
                check($sformatf("vec[%0d] read 0x%0h", i, tbl[i].addr), d, tbl[i].exp);
            end
        end
        check("A[5] on mm_a", mm_a[5*DW +: DW], 36'hF_00000001);
        check("B[10] on mm_b", mm_b[10*DW +: DW], 36'h7_12345678);

        for (int i = 0; i < 16; i++) begin
            a_m[i] = (i / 4 == i % 4) ? (64'sd1 <<< FRAC) : 0;
            b_m[i] = longint'(i) <<< FRAC;
        end
        load_mats();
        compute_ref();
        run_op("identity", 3, 32'h1, 3'b010, 3);
        check_c("identity");

        for (int r = 0; r < 4; r++) begin
            int dly;
            dly = $urandom_range(1, 20);
            randomize_mats();
            load_mats();
            compute_ref();
            run_op($sformatf("rand%0d", r), dly, 32'h1, 3'b010, dly);
            check_c($sformatf("rand%0d", r));
        end

        randomize_mats();
        load_mats();
        compute_ref();
        stub_delay = 40;
        p0 = start_pulses;
        bus_write(ADDR_CTRL, 32'h1);
        repeat (5) @(posedge clk); #1;
        bus_write(ea(2'b00, 1'b0, 0), 32'h1234);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_CTRL, d);
        check("lockout status busy", d, 32'h1);
        t = a_m[0];
        check("lockout mm_a[0] unchanged", mm_a[0 +: DW], t[DW-1:0]);
        wait_done("lockout");
        check("lockout start pulses", start_pulses - p0, 1);
        bus_read(ADDR_CYCLES, d);
        check("lockout cycle count", d, 40);
        bus_read(ea(2'b00, 1'b0, 0), d);
        check("lockout A[0] lo readback", d, lo_of(a_m[0]));
        check_c("lockout");

        bus_write(ADDR_CTRL, 32'h2);
        bus_write(ADDR_CTRL, 32'h4);
        check("irq low before run", irq, 0);
        randomize_mats();
        load_mats();
        compute_ref();
        run_op("irq", 5, 32'h5, 3'b010, 5);
        check("irq high after done", irq, 1);
        bus_write(ADDR_CTRL, 32'h6);
        check("irq dropped by clear", irq, 0);
        bus_read(ADDR_CTRL, d);
        check("status after clear", d, 0);

        run_op("timeout", -1, 32'h5, 3'b100, TMO);
        check("timeout irq low", irq, 0);
        check_c("timeout");

        man_c = '1;
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        bus_read(ea(2'b10, 1'b0, 0), d);
        check("stray mm_done ignored", d, lo_of(c_m[0]));

        randomize_mats();
        load_mats();
        compute_ref();
        stub_delay = 10;
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid-op reset mm_start low", mm_start, 0);
        reset_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        bus_read(ADDR_CTRL, d);
        check("post-reset status", d, 0);
        check("post-reset irq", irq, 0);
        check("post-reset mm_a zero", mm_a == '0, 1);
        for (int i = 0; i < 16; i++) begin
            bus_read(ea(2'b10, 1'b0, i), d);
            check($sformatf("post-reset C[%0d] lo", i), d, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
